// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner with frame-based debounce and a one-deep key register.
// Define KEYPAD_MULTI_REJECT_EN to treat frames with two or more pressed keys as empty.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam logic [1:0]  IDLE       = 2'd0;
    localparam logic [1:0]  DB_PRESS   = 2'd1;
    localparam logic [1:0]  PRESSED    = 2'd2;
    localparam logic [1:0]  DB_RELEASE = 2'd3;
    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_TARGET  = 4'(DEBOUNCE);

    logic [15:0] div_q;
    logic [1:0]  row_q;
    logic [2:0]  col_s1, col_s2;
    logic        sample, frame_end;

    logic        acc_hit;
    logic [3:0]  acc_code;
    logic [1:0]  acc_lows;

    logic [2:0]  lows;
    logic [1:0]  row_col, row_nlows, f_lows;
    logic [3:0]  row_code, f_code;
    logic [2:0]  lows_sum;
    logic        f_any, f_hit;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cand_q, cand_d;
    logic        accept;

    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (row_q == 2'd3);
    assign row       = ~(4'b0001 << row_q);
    assign key_held  = (state_q == PRESSED) || (state_q == DB_RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            row_q  <= '0;
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
            if (sample) begin
                div_q <= '0;
                row_q <= row_q + 2'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    // Rows are scanned in ascending order, so the first hit in a frame already holds the lowest code.
    always_comb begin
        lows      = ~col_s2;
        row_col   = lows[0] ? 2'd0 : (lows[1] ? 2'd1 : 2'd2);
        row_code  = {2'b00, row_q} * 4'd3 + {2'b00, row_col};
        row_nlows = {1'b0, lows[0]} + {1'b0, lows[1]} + {1'b0, lows[2]};
        lows_sum  = {1'b0, acc_lows} + {1'b0, row_nlows};
        f_lows    = (lows_sum > 3'd2) ? 2'd2 : lows_sum[1:0];
        f_any     = acc_hit | (|lows);
        f_code    = acc_hit ? acc_code : row_code;
`ifdef KEYPAD_MULTI_REJECT_EN
        f_hit     = f_any && (f_lows < 2'd2);
`else
        f_hit     = f_any;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit  <= 1'b0;
            acc_code <= '0;
            acc_lows <= '0;
        end else if (sample) begin
            if (frame_end) begin
                acc_hit  <= 1'b0;
                acc_code <= '0;
                acc_lows <= '0;
            end else begin
                acc_hit  <= f_any;
                acc_code <= f_code;
                acc_lows <= f_lows;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (f_hit) begin
                        state_d = DB_PRESS;
                        cand_d  = f_code;
                        cnt_d   = 4'd1;
                    end
                end
                DB_PRESS: begin
                    if (!f_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (f_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cand_d = f_code;
                        cnt_d  = 4'd1;
                    end
                end
                PRESSED: begin
                    if (!f_hit) begin
                        state_d = DB_RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                default: begin
                    if (f_hit) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
            // Checking the updated count lets DEBOUNCE=1 resolve on the very first frame.
            if (state_d == DB_PRESS && cnt_d == DB_TARGET) begin
                state_d = PRESSED;
                cnt_d   = '0;
                accept  = 1'b1;
            end
            if (state_d == DB_RELEASE && cnt_d == DB_TARGET) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            if (accept) begin
                key_code  <= cand_d;
                key_valid <= 1'b1;
                if (key_valid && !key_ack) begin
                    overrun <= 1'b1;
                end
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each row is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE, default 4: consecutive identical scan frames needed to accept a press or release; legal range 1..15.
REQ-003 CLK  in  1  system clock; all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 COL  in  3  keypad columns, active-low: a pressed key in the driven row pulls its column low.
REQ-006 ROW  out  4  keypad rows, active-low one-hot drive.
REQ-007 KEY_CODE  out  4  index of the accepted key, row*3+col, values 0..11.
REQ-008 KEY_VALID  out  1  high while KEY_CODE holds an unacknowledged key.
REQ-009 KEY_ACK  in  1  consumer acknowledge, sampled on CLK.
REQ-010 KEY_HELD  out  1  high while the debounced key is physically down.
REQ-011 OVERRUN  out  1  sticky flag: a key was accepted while KEY_VALID was already high.

Function
REQ-012 Row counter steps ROW 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles; four rows make one frame.
REQ-013 Synchronise COL through two flops, then sample it on the last cycle of each row dwell only.
REQ-014 Frame result is {hit, code}: hit=1 when at least one sampled column was low in any row; code is the lowest row*3+col with a low column.
REQ-015 FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE; frame results are evaluated at frame end only.
REQ-016 IDLE: hit -> DB_PRESS, latch candidate code, count=1; no hit -> stay in IDLE.
REQ-017 DB_PRESS: same code -> count+1; different code -> reload candidate, count=1; no hit -> IDLE.
REQ-018 When count reaches DEBOUNCE -> PRESSED, KEY_HELD=1, accept the key (REQ-021); with DEBOUNCE=1, acceptance happens at the first hit frame end.
REQ-019 PRESSED: no hit -> DB_RELEASE, count=1; any hit (same or different code) -> stay; no autorepeat.
REQ-020 DB_RELEASE: no hit -> count+1, and at DEBOUNCE -> IDLE with KEY_HELD=0; hit -> PRESSED.
REQ-021 Accept: KEY_CODE<=candidate and KEY_VALID<=1 on the cycle after the decisive frame end; if KEY_VALID was already 1 and not being acked that cycle, KEY_CODE is overwritten and OVERRUN<=1.
REQ-022 KEY_ACK while KEY_VALID=1 clears KEY_VALID the next cycle; KEY_ACK while KEY_VALID=0 is ignored.
REQ-023 KEY_ACK coinciding with an accept: the new key wins, KEY_VALID stays 1, OVERRUN unchanged.
REQ-024 OVERRUN clears only on reset.
REQ-025 Divider and row counters wrap silently; a full frame lasts exactly 4*SCAN_DIV cycles.

Reset
REQ-026 While RESET=0: ROW=1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0, OVERRUN=0, FSM=IDLE, all counters and synchronisers cleared.
REQ-027 Reset asserted mid-debounce or mid-press discards the key; after release, scanning restarts at row 0 on the first clock edge.

Configuration
REQ-028 Macro KEYPAD_MULTI_REJECT_EN defined: a frame with two or more low sampled columns in total is treated as hit=0 (ghost rejection).
REQ-029 Macro undefined: multiple keys resolve to the lowest code per REQ-014.

Verification
REQ-030 SCAN_DIV=4, DEBOUNCE=2; hold row1/col2 low for 3 frames -> KEY_CODE=5, one KEY_VALID rise 1 cycle after frame 2 end, KEY_HELD=1.
REQ-031 Bounce press for 1 frame only -> KEY_VALID stays 0 and FSM returns to IDLE.
REQ-032 Accept code 5, no ACK, release and press code 0 -> KEY_CODE=0, OVERRUN=1; KEY_ACK -> KEY_VALID=0 next cycle.
REQ-033 Hold codes 1 and 4 together -> with macro defined, no key accepted; without macro, KEY_CODE=1.
REQ-034 Assert RESET for 1 cycle in PRESSED -> all outputs at reset values, ROW=1110, no KEY_VALID until a fresh debounced press.
REQ-035 KEY_ACK on the same cycle as a new accept -> KEY_VALID remains 1 with the new code, OVERRUN=0.
